// File: rtl/aplic_irq_stimulus.sv
// Interrupt-source stimulus generator for APLIC latency measurement.
// Fires bursts of interrupts on one source line, strobes the latency counter,
// waits for the claim acknowledge (or a timeout) and tallies the outcome.
module aplic_irq_stimulus #(
    parameter int unsigned NR_SRC = 32,
    parameter int unsigned GAP_W  = 16,
    parameter int unsigned TO_W   = 16,
    localparam int unsigned SRC_W = $clog2(NR_SRC)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [SRC_W-1:0]  cfg_src_i,
    input  logic [15:0]       cfg_count_i,
    input  logic [GAP_W-1:0]  cfg_gap_i,
    input  logic [TO_W-1:0]   cfg_timeout_i,
    input  logic              cfg_level_i,
    input  logic              ack_i,
    input  logic              abort_i,
    output logic [NR_SRC-1:0] irq_o,
    output logic              meas_rst_o,
    output logic              meas_start_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       sent_o,
    output logic [15:0]       acked_o,
    output logic [15:0]       timeouts_o
);

    typedef enum logic [2:0] {StIdle, StArm, StFire, StWaitAck, StGap, StDone} state_e;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [15:0]        count_q, count_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [TO_W-1:0]    tmo_q, tmo_d;
    logic               level_q, level_d;
    logic               empty_q, empty_d;
    logic [TO_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [15:0]        sent_q, sent_d;
    logic [15:0]        acked_q, acked_d;
    logic [15:0]        timeouts_q, timeouts_d;

    logic src_valid;
    logic timeout_hit;
    logic gap_last;
    logic more;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign src_valid = (cfg_src_i != '0) && (32'(cfg_src_i) < NR_SRC);
    // wait_cnt is 0 in the FIRE cycle, so the line has been up wait_cnt+1 cycles
    // by the end of the current cycle; time out once that reaches the limit.
    assign timeout_hit = (tmo_q != '0) && (wait_cnt_q >= tmo_q - TO_W'(1));
    assign gap_last    = (gap_cnt_q == gap_q - GAP_W'(1));
    assign more        = (sent_q < count_q);

    // State and configuration registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            src_q      <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            tmo_q      <= '0;
            level_q    <= 1'b0;
            empty_q    <= 1'b0;
            wait_cnt_q <= '0;
            gap_cnt_q  <= '0;
            sent_q     <= '0;
            acked_q    <= '0;
            timeouts_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            tmo_q      <= tmo_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            wait_cnt_q <= wait_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sent_q     <= sent_d;
            acked_q    <= acked_d;
            timeouts_q <= timeouts_d;
        end
    end

    // Next-state logic; abort overrides everything and freezes the tallies.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        count_d    = count_q;
        gap_d      = gap_q;
        tmo_d      = tmo_q;
        level_d    = level_q;
        empty_d    = empty_q;
        wait_cnt_d = wait_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sent_d     = sent_q;
        acked_d    = acked_q;
        timeouts_d = timeouts_q;

        if (abort_i && state_q != StIdle) begin
            state_d = StDone;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfg_valid_i) begin
                        src_d      = cfg_src_i;
                        count_d    = cfg_count_i;
                        gap_d      = cfg_gap_i;
                        tmo_d      = cfg_timeout_i;
                        level_d    = cfg_level_i;
                        empty_d    = !src_valid || (cfg_count_i == '0);
                        sent_d     = '0;
                        acked_d    = '0;
                        timeouts_d = '0;
                        state_d    = StArm;
                    end
                end
                StArm: begin
                    // An empty burst passes through ARM silently and ends.
                    wait_cnt_d = '0;
                    state_d    = empty_q ? StDone : StFire;
                end
                StFire: begin
                    sent_d     = sat_inc(sent_q);
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                    state_d    = StWaitAck;
                end
                StWaitAck: begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                    if (ack_i || timeout_hit) begin
                        if (ack_i) begin
                            acked_d = sat_inc(acked_q);
                        end else begin
                            timeouts_d = sat_inc(timeouts_q);
                        end
                        gap_cnt_d = '0;
                        if (!more) begin
                            state_d = StDone;
                        end else if (gap_q == '0) begin
                            state_d = StArm;
                        end else begin
                            state_d = StGap;
                        end
                    end
                end
                StGap: begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    if (gap_last) begin
                        state_d = StArm;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        irq_o = '0;
        if (state_q == StFire || (state_q == StWaitAck && level_q)) begin
            irq_o[src_q] = 1'b1;
        end
    end

    assign cfg_ready_o  = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StDone);
    assign meas_rst_o   = (state_q == StArm) && !empty_q;
    assign meas_start_o = (state_q == StFire) || (state_q == StWaitAck);
    assign sent_o       = sent_q;
    assign acked_o      = acked_q;
    assign timeouts_o   = timeouts_q;

endmodule

// File: tb/tb_aplic_irq_stimulus.sv
// Directed, table-driven bench for aplic_irq_stimulus.
module tb_aplic_irq_stimulus;

    localparam int NR_SRC = 32;
    localparam int SRC_W  = 5;
    localparam int GAP_W  = 16;
    localparam int TO_W   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [SRC_W-1:0]  cfg_src;
    logic [15:0]       cfg_count;
    logic [GAP_W-1:0]  cfg_gap;
    logic [TO_W-1:0]   cfg_timeout;
    logic              cfg_level;
    logic              ack;
    logic              abort;
    logic [NR_SRC-1:0] irq;
    logic              meas_rst;
    logic              meas_start;
    logic              busy;
    logic              done;
    logic [15:0]       sent;
    logic [15:0]       acked;
    logic [15:0]       timeouts;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aplic_irq_stimulus #(
        .NR_SRC(NR_SRC),
        .GAP_W (GAP_W),
        .TO_W  (TO_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_src_i    (cfg_src),
        .cfg_count_i  (cfg_count),
        .cfg_gap_i    (cfg_gap),
        .cfg_timeout_i(cfg_timeout),
        .cfg_level_i  (cfg_level),
        .ack_i        (ack),
        .abort_i      (abort),
        .irq_o        (irq),
        .meas_rst_o   (meas_rst),
        .meas_start_o (meas_start),
        .busy_o       (busy),
        .done_o       (done),
        .sent_o       (sent),
        .acked_o      (acked),
        .timeouts_o   (timeouts)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ack_d: ack is driven in the cycle that many cycles after the FIRE cycle (-1: never).
    // e_done: cycle (accept cycle = 0) in which done_o is seen.
    typedef struct {
        int src; int count; int gap; int tmo; int level; int ack_d; int noise;
        int e_done; int e_pulses; int e_high; int e_rsts; int e_sent; int e_acked; int e_to;
    } vec_t;

    vec_t vecs[11];

    task automatic set_cfg(input int src, input int count, input int gap, input int tmo,
                           input int level);
        cfg_src     = SRC_W'(src);
        cfg_count   = 16'(count);
        cfg_gap     = GAP_W'(gap);
        cfg_timeout = TO_W'(tmo);
        cfg_level   = (level != 0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int done_k = -1;
        int dones = 0, pulses = 0, high = 0, rsts = 0, other = 0, age = 0;
        int idle_ok = 0;
        logic prev_line = 1'b0, prev_start = 1'b0, line;
        logic [NR_SRC-1:0] mask;
        string t;
        t = $sformatf("v%0d", idx);
        mask = '1;
        if (v.src > 0 && v.src < NR_SRC) mask[v.src] = 1'b0;
        @(negedge clk);
        set_cfg(v.src, v.count, v.gap, v.tmo, v.level);
        cfg_valid = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (v.noise != 0 && k >= 3 && k <= 6) begin
                cfg_valid = 1'b1;
                cfg_src   = SRC_W'(9);
                cfg_count = 16'd5;
            end else begin
                cfg_valid = 1'b0;
            end
            line = (v.src > 0 && v.src < NR_SRC) ? irq[v.src] : 1'b0;
            if (line) high++;
            if (line && !prev_line) pulses++;
            if ((irq & mask) != '0) other++;
            if (meas_start && !prev_start) age = 0;
            else if (meas_start) age++;
            if (meas_rst) rsts++;
            if (done) begin
                dones++;
                if (done_k < 0) done_k = k;
            end
            ack = (v.ack_d >= 0) && meas_start && (age == v.ack_d);
            prev_line  = line;
            prev_start = meas_start;
            if (done_k >= 0 && k == done_k + 1) begin
                idle_ok = (!busy && cfg_ready) ? 1 : 0;
                break;
            end
        end
        ack       = 1'b0;
        cfg_valid = 1'b0;
        check({t, " done_cycle"}, done_k, v.e_done);
        check({t, " done_pulses"}, dones, 1);
        check({t, " irq_rises"}, pulses, v.e_pulses);
        check({t, " irq_high_cycles"}, high, v.e_high);
        check({t, " other_lines"}, other, 0);
        check({t, " meas_rst_strobes"}, rsts, v.e_rsts);
        check({t, " sent"}, int'(sent), v.e_sent);
        check({t, " acked"}, int'(acked), v.e_acked);
        check({t, " timeouts"}, int'(timeouts), v.e_to);
        check({t, " idle_after_done"}, idle_ok, 1);
    endtask

    initial begin
        int fires, age, reached;
        logic prev;

        //             src cnt gap tmo lvl ack noise done rise high rst sent ack to
        vecs[0]  = '{5,  3,  4,  0,  0,  10, 0,  45,  3,   3,  3,  3,   3,  0};
        vecs[1]  = '{7,  2,  3,  20, 1,  -1, 0,  46,  2,   40, 2,  2,   0,  2};
        vecs[2]  = '{9,  1,  0,  8,  1,  7,  0,  10,  1,   8,  1,  1,   1,  0};
        vecs[3]  = '{9,  1,  0,  8,  1,  8,  0,  10,  1,   8,  1,  1,   0,  1};
        vecs[4]  = '{3,  1,  0,  0,  1,  30, 0,  33,  1,   31, 1,  1,   1,  0};
        vecs[5]  = '{2,  2,  0,  0,  0,  1,  0,  7,   2,   2,  2,  2,   2,  0};
        vecs[6]  = '{4,  0,  2,  5,  1,  1,  0,  2,   0,   0,  0,  0,   0,  0};
        vecs[7]  = '{0,  3,  1,  5,  1,  1,  0,  2,   0,   0,  0,  0,   0,  0};
        vecs[8]  = '{31, 1,  0,  0,  0,  2,  0,  5,   1,   1,  1,  1,   1,  0};
        vecs[9]  = '{6,  2,  2,  3,  0,  -1, 0,  11,  2,   2,  2,  2,   0,  2};
        vecs[10] = '{5,  1,  0,  6,  1,  -1, 1,  8,   1,   6,  1,  1,   0,  1};

        rst = 1'b1;
        cfg_valid = 1'b0;
        ack = 1'b0;
        abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset cfg_ready", int'(cfg_ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset irq", int'(irq), 0);
        check("reset meas_rst", int'(meas_rst), 0);
        check("reset meas_start", int'(meas_start), 0);
        check("reset sent", int'(sent), 0);
        check("reset acked", int'(acked), 0);
        check("reset timeouts", int'(timeouts), 0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Abort during the wait of the 2nd of 4 interrupts (1st acked).
        @(negedge clk);
        set_cfg(5, 4, 2, 0, 1);
        cfg_valid = 1'b1;
        fires = 0;
        age = 0;
        prev = 1'b0;
        reached = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            if (meas_start && !prev) begin
                fires++;
                age = 0;
            end else if (meas_start) begin
                age++;
            end
            prev = meas_start;
            ack = (fires == 1) && meas_start && (age == 3);
            if (fires == 2 && age == 2) begin
                reached = 1;
                break;
            end
        end
        check("abort reached 2nd wait", reached, 1);
        check("abort irq high before", int'(irq[5]), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort irq", int'(irq), 0);
        check("abort meas_start", int'(meas_start), 0);
        check("abort done", int'(done), 1);
        check("abort sent", int'(sent), 2);
        check("abort acked", int'(acked), 1);
        check("abort timeouts", int'(timeouts), 0);
        @(negedge clk);
        check("abort busy after", int'(busy), 0);
        check("abort ready after", int'(cfg_ready), 1);

        // Reset while a level-mode line is being held.
        @(negedge clk);
        set_cfg(7, 3, 0, 0, 1);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("hold irq before reset", int'(irq[7]), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset irq", int'(irq), 0);
        check("midreset cfg_ready", int'(cfg_ready), 1);
        check("midreset busy", int'(busy), 0);
        check("midreset meas_start", int'(meas_start), 0);
        check("midreset sent", int'(sent), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
